// File: rtl/qc_shift_scheduler.sv
// qc_shift_scheduler: walks a QC-LDPC shift table row-major, issues shifter commands and latency-matched row/col tags.
// Define QC_SCHED_FAST_SKIP_EN to jump straight to the next non-null entry instead of spending a cycle per null.
module qc_shift_scheduler #(
  parameter int MAXZ = 81,
  parameter int ROWS = 12,
  parameter int COLS = 24,
  localparam int SHIFT_W = $clog2(MAXZ),
  localparam int LAT = $clog2(MAXZ),
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS)
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [RW-1:0]      cfg_row,
  input  logic [CW-1:0]      cfg_col,
  input  logic               cfg_null,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [RW:0]        num_rows,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               iss_ready,
  output logic               iss_valid,
  output logic [CW-1:0]      iss_col,
  output logic [SHIFT_W-1:0] shift_val,
  output logic               out_valid,
  output logic [RW-1:0]      out_row,
  output logic [CW-1:0]      out_col,
  output logic               out_row_last,
  output logic               cfg_err
);
  localparam int TW = RW + CW + 2;
  localparam int NW = $clog2(LAT + 1);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [SHIFT_W-1:0] shift_q [ROWS][COLS];
  logic [SHIFT_W-1:0] shift_d [ROWS][COLS];
  logic [COLS-1:0] mask_q [ROWS];
  logic [COLS-1:0] mask_d [ROWS];
  logic [TW-1:0] pipe_q [LAT];
  logic [TW-1:0] pipe_d [LAT];
  logic [RW-1:0] r_q, r_d, er;
  logic [CW-1:0] c_q, c_d, ec;
  logic [RW:0] nrows_q, nrows_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, nn, hit, last, at_end;
  // (er, ec) is the entry examined this cycle; hit=0 means nothing non-null remains
  always_comb begin
    er = r_q;
    ec = c_q;
    nn = mask_q[r_q][c_q];
    hit = 1'b1;
`ifdef QC_SCHED_FAST_SKIP_EN
    hit = 1'b0;
    nn = 1'b0;
    for (int i = ROWS - 1; i >= 0; i--)
      for (int j = COLS - 1; j >= 0; j--)
        if (mask_q[i][j] && i < int'(nrows_q) && (i > int'(r_q) || (i == int'(r_q) && j >= int'(c_q)))) begin
          hit = 1'b1;
          nn = 1'b1;
          er = RW'(i);
          ec = CW'(j);
        end
`endif
  end
  assign last = ((mask_q[er] >> ec) >> 1) == '0;
  assign at_end = !hit || ({1'b0, er} == nrows_q - (RW+1)'(1) && ec == CW'(COLS - 1));
  assign iss_valid = state_q == SCAN && nn && iss_ready;
  assign iss_col = iss_valid ? ec : '0;
  assign shift_val = iss_valid ? shift_q[er][ec] : '0;
  assign busy = state_q == SCAN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign {out_valid, out_row, out_col, out_row_last} = pipe_q[LAT-1];
  assign cfg_err = err_q;
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    c_d = c_q;
    nrows_d = nrows_q;
    cnt_d = cnt_q;
    err_d = err_q;
    shift_d = shift_q;
    mask_d = mask_q;
    if (cfg_we) begin
      err_d = err_d || busy || {1'b0, cfg_shift} >= (SHIFT_W+1)'(MAXZ);
      if (!busy) begin
        shift_d[cfg_row][cfg_col] = cfg_shift;
        mask_d[cfg_row][cfg_col] = !cfg_null;
      end
    end
    case (state_q)
      IDLE: if (start) begin
        nrows_d = num_rows > (RW+1)'(ROWS) ? (RW+1)'(ROWS) : num_rows;
        err_d = err_d || num_rows > (RW+1)'(ROWS);
        r_d = '0;
        c_d = '0;
        state_d = num_rows == '0 ? DONE : SCAN;
      end
      SCAN: if (!nn || iss_ready) begin
        r_d = ec == CW'(COLS - 1) ? er + RW'(1) : er;
        c_d = ec == CW'(COLS - 1) ? '0 : ec + CW'(1);
        cnt_d = '0;
        state_d = at_end ? DRAIN : SCAN;
      end
      DRAIN: begin
        cnt_d = cnt_q + NW'(1);
        state_d = cnt_q == NW'(LAT - 1) ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    pipe_d[0] = iss_valid ? {1'b1, er, ec, last} : '0;
    for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      r_q <= '0;
      c_q <= '0;
      nrows_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      shift_q <= '{default: '0};
      mask_q <= '{default: '0};
      pipe_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      c_q <= c_d;
      nrows_q <= nrows_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      shift_q <= shift_d;
      mask_q <= mask_d;
      pipe_q <= pipe_d;
    end
  end
endmodule
